// File: rtl/counter_ctrl.sv
// counter_ctrl: Wishbone-configured count register with prescaled tick,
// compare-match detection, one-shot / auto-reload modes and an IRQ line.
// The count is updated from at most one source per cycle, in priority order:
// Wishbone COUNT write, LA load, prescaled tick.
module counter_ctrl #(
  parameter int          BITS       = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          PRESC_BITS = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_load_i,
  input  logic [BITS-1:0] la_data_i,
  output logic [BITS-1:0] count_o,
  output logic            match_o,
  output logic            irq_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_ONESHOT    = 1;
  localparam int CTRL_IRQ_EN     = 2;
  localparam int CTRL_DOWN       = 3;
  localparam int CTRL_AUTORELOAD = 4;

  // Byte-lane merge of write data over the current register contents.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{sel[i]}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [4:0]            ctrl_q, ctrl_d;
  logic [PRESC_BITS-1:0] presc_rl_q, presc_rl_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [BITS-1:0]       cmp_q, cmp_d;
  logic [BITS-1:0]       count_q, count_d;
  logic                  match_st_q, match_st_d;
  logic                  match_q, match_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;

  logic            hit, req, acc, wr;
  logic [2:0]      off;
  logic [31:0]     rd_val, wr_val;
  logic            tick, tick_upd, cnt_wr;
  logic [BITS-1:0] step_val;
  logic            tick_match;
  logic            unused_adr;

  assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req      = wbs_cyc_i & wbs_stb_i & hit;
  assign acc      = req & ~ack_q;
  assign wr       = acc & wbs_we_i;
  assign off      = wbs_adr_i[4:2];
  assign unused_adr = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], BASE_ADDR[7:0]};

  assign tick     = ctrl_q[CTRL_EN] & (presc_q == presc_rl_q);
  assign cnt_wr   = wr & (off == OFF_COUNT);
  assign tick_upd = tick & ~cnt_wr & ~la_load_i;
  assign step_val = ctrl_q[CTRL_DOWN] ? (count_q - BITS'(1)) : (count_q + BITS'(1));
  assign tick_match = tick_upd & (step_val == cmp_q);

  // Read mux: current (pre-write) value of the addressed register, zero-extended.
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL:   rd_val = 32'(ctrl_q);
      OFF_PRESC:  rd_val = 32'(presc_rl_q);
      OFF_CMP:    rd_val = 32'(cmp_q);
      OFF_COUNT:  rd_val = 32'(count_q);
      OFF_STATUS: rd_val = {30'd0, ctrl_q[CTRL_EN], match_st_q};
      default:    rd_val = '0;
    endcase
  end

  assign wr_val = byte_merge(rd_val, wbs_dat_i, wbs_sel_i);

  // Next-state: bus handshake, register writes, prescaler and count sequencing.
  always_comb begin
    ctrl_d     = ctrl_q;
    presc_rl_d = presc_rl_q;
    cmp_d      = cmp_q;
    count_d    = count_q;
    match_st_d = match_st_q;
    match_d    = tick_match;
    ack_d      = acc;
    dat_d      = acc ? rd_val : dat_q;

    // Prescaler idles at 0 while disabled, wraps on tick, restarts on CTRL write.
    if (!ctrl_q[CTRL_EN] || tick) presc_d = '0;
    else                          presc_d = presc_q + PRESC_BITS'(1);

    // Count source priority: bus write, LA load, then tick.
    if (cnt_wr) begin
      count_d = BITS'(wr_val);
    end else if (la_load_i) begin
      count_d = la_data_i;
    end else if (tick) begin
      count_d = step_val;
      if (tick_match && ctrl_q[CTRL_AUTORELOAD])
        count_d = ctrl_q[CTRL_DOWN] ? '1 : '0;
    end

    // One-shot stops the counter on match; an explicit CTRL write overrides it.
    if (tick_match && ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_EN] = 1'b0;
    if (wr && off == OFF_CTRL) begin
      ctrl_d  = wr_val[4:0];
      presc_d = '0;
    end

    if (wr && off == OFF_PRESC) presc_rl_d = PRESC_BITS'(wr_val);
    if (wr && off == OFF_CMP)   cmp_d      = BITS'(wr_val);

    // Sticky match: W1C clear, but a simultaneous set wins.
    if (wr && off == OFF_STATUS && wbs_sel_i[0] && wbs_dat_i[0]) match_st_d = 1'b0;
    if (tick_match) match_st_d = 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q     <= '0;
      presc_rl_q <= '0;
      presc_q    <= '0;
      cmp_q      <= '0;
      count_q    <= '0;
      match_st_q <= 1'b0;
      match_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      presc_rl_q <= presc_rl_d;
      presc_q    <= presc_d;
      cmp_q      <= cmp_d;
      count_q    <= count_d;
      match_st_q <= match_st_d;
      match_q    <= match_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign count_o   = count_q;
  assign match_o   = match_q;
  assign irq_o     = match_st_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: table of register accesses, hand-written corner
// sequences, and randomized traffic checked against a behavioural model.
module tb_counter_ctrl;
  localparam int          BITS = 32;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          PB   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        la_load;
  logic [BITS-1:0] la_data;
  logic [BITS-1:0] count;
  logic        match, irq;

  always #5 clk = ~clk;

  counter_ctrl #(.BITS(BITS), .BASE_ADDR(BASE), .PRESC_BITS(PB)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_load_i(la_load), .la_data_i(la_data),
    .count_o(count), .match_o(match), .irq_o(irq)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  longint unsigned MODV = 64'd1 << BITS;
  logic [4:0]      m_ctrl;
  longint unsigned m_presc, m_cmp, m_cnt, m_pc;
  bit              m_sticky, m_ack, m_match;
  logic [31:0]     m_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_presc = 0; m_cmp = 0; m_cnt = 0; m_pc = 0;
    m_sticky = 0; m_ack = 0; m_match = 0; m_dat = '0;
  endtask

  function automatic logic [31:0] m_read(input int o);
    case (o)
      0: return 32'(m_ctrl);
      1: return 32'(m_presc);
      2: return 32'(m_cmp);
      3: return 32'(m_cnt);
      4: return {30'd0, m_ctrl[0], m_sticky};
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge's worth of the rules to the model using current inputs.
  task automatic model_edge();
    bit req, acc, wrt, tck, hitm, clr;
    int o;
    logic [31:0] mask, oldv, newv;
    longint unsigned nc;
    logic [4:0] nctrl;
    longint unsigned npc;
    req  = cyc && stb && (adr[31:8] == BASE[31:8]);
    acc  = req && !m_ack;
    wrt  = acc && we;
    o    = int'(adr[4:2]);
    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{sel[i]}};
    oldv = m_read(o);
    newv = (oldv & ~mask) | (wdat & mask);
    tck  = m_ctrl[0] && (m_pc == m_presc);
    hitm = 0;
    nc   = m_cnt;
    nctrl = m_ctrl;
    if (wrt && o == 3)      nc = longint'(newv) % MODV;
    else if (la_load)       nc = longint'(la_data);
    else if (tck) begin
      nc = m_ctrl[3] ? (m_cnt + MODV - 1) % MODV : (m_cnt + 1) % MODV;
      if (nc == m_cmp) begin
        hitm = 1;
        if (m_ctrl[4]) nc = m_ctrl[3] ? MODV - 1 : 0;
        if (m_ctrl[1]) nctrl[0] = 1'b0;
      end
    end
    npc = (!m_ctrl[0] || tck) ? 0 : m_pc + 1;
    if (wrt && o == 0) begin nctrl = newv[4:0]; npc = 0; end
    if (wrt && o == 1) m_presc = longint'(newv) % (64'd1 << PB);
    if (wrt && o == 2) m_cmp   = longint'(newv) % MODV;
    clr = wrt && o == 4 && sel[0] && wdat[0];
    m_sticky = hitm || (m_sticky && !clr);
    if (acc) m_dat = oldv;
    m_ack   = acc;
    m_match = hitm;
    m_cnt   = nc;
    m_ctrl  = nctrl;
    m_pc    = npc;
  endtask

  task automatic compare_outputs();
    check("count", count, 32'(m_cnt));
    check("ack", 32'(ack), 32'(m_ack));
    if (m_ack) check("rdata", rdat, m_dat);
    check("match", 32'(match), 32'(m_match));
    check("irq", 32'(irq), 32'(m_sticky && m_ctrl[2]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; wdat = '0;
  endtask

  // One Wishbone access plus an idle cycle; returns data seen on the ack cycle.
  task automatic wb_cycle(input bit w, input logic [2:0] o, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r, output logic a);
    cyc = 1; stb = 1; we = w; sel = s; adr = BASE | {27'd0, o, 2'b00}; wdat = d;
    step();
    r = rdat; a = ack;
    bus_idle();
    step();
  endtask

  task automatic wb_wr(input logic [2:0] o, input logic [31:0] d);
    logic [31:0] r; logic a;
    wb_cycle(1'b1, o, d, 4'hF, r, a);
  endtask

  typedef struct {
    bit          w;
    logic [2:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit w, input logic [2:0] o, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] e);
    vec_t v;
    v.w = w; v.off = o; v.dat = d; v.sel = s; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] r;
    logic a;

    // Register-access vectors; exp is the value returned on the ack cycle
    // (for writes, the pre-write contents).
    for (int i = 0; i < 8; i++) add(0, 3'(i), 32'h0, 4'hF, 32'h0);
    add(1, 3'd1, 32'h0000_1234, 4'hF, 32'h0);
    add(0, 3'd1, 32'h0,         4'hF, 32'h0000_1234);
    add(1, 3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0000_1234);
    add(0, 3'd1, 32'h0,         4'hF, 32'h0000_FFFF);
    add(1, 3'd2, 32'hDEAD_BEEF, 4'b0101, 32'h0);
    add(0, 3'd2, 32'h0,         4'hF, 32'h00AD_00EF);
    add(1, 3'd3, 32'h1122_3344, 4'hF, 32'h0);
    add(1, 3'd3, 32'hAABB_CCDD, 4'b0010, 32'h1122_3344);
    add(0, 3'd3, 32'h0,         4'hF, 32'h1122_CC44);
    add(1, 3'd6, 32'h0000_FFFF, 4'hF, 32'h0);
    add(0, 3'd6, 32'h0,         4'hF, 32'h0);
    add(1, 3'd0, 32'h0000_001E, 4'h1, 32'h0);
    add(0, 3'd0, 32'h0,         4'hF, 32'h0000_001E);
    add(1, 3'd0, 32'hFFFF_FFE0, 4'hF, 32'h0000_001E);
    add(0, 3'd0, 32'h0,         4'hF, 32'h0);
    add(0, 3'd4, 32'h0,         4'hF, 32'h0);

    rst = 1; la_load = 0; la_data = '0;
    bus_idle();
    model_reset();
    #2;
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_dat", rdat, 32'h0);
    check("reset_count", count, 32'h0);
    check("reset_match", 32'(match), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rst = 0;

    foreach (tbl[i]) begin
      wb_cycle(tbl[i].w, tbl[i].off, tbl[i].dat, tbl[i].sel, r, a);
      check($sformatf("tbl%0d_ack", i), 32'(a), 32'h1);
      check($sformatf("tbl%0d_data", i), r, tbl[i].exp);
      check($sformatf("tbl%0d_ackdrop", i), 32'(ack), 32'h0);
    end

    // Back-to-back request: ack every other cycle
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = BASE | 32'h8; wdat = '0;
    step(); check("b2b_ack0", 32'(ack), 32'h1);
    step(); check("b2b_ack1", 32'(ack), 32'h0);
    step(); check("b2b_ack2", 32'(ack), 32'h1);
    step(); check("b2b_ack3", 32'(ack), 32'h0);
    // Address window miss
    adr = BASE + 32'h100;
    repeat (3) begin step(); check("miss_ack", 32'(ack), 32'h0); end
    bus_idle(); step();

    // Up count with prescale 3, match at 5
    wb_wr(3'd3, 32'h0); wb_wr(3'd1, 32'd3); wb_wr(3'd2, 32'd5);
    wb_wr(3'd0, 32'h5);
    repeat (18) step();
    check("up_pre_match", 32'(match), 32'h0);
    step();
    check("up_count5", count, 32'd5);
    check("up_match", 32'(match), 32'h1);
    check("up_irq", 32'(irq), 32'h1);
    step();
    check("up_match_once", 32'(match), 32'h0);
    wb_wr(3'd4, 32'h1);
    check("w1c_irq", 32'(irq), 32'h0);
    wb_wr(3'd0, 32'h0);

    // Down count wraps through zero
    wb_wr(3'd1, 32'd0); wb_wr(3'd3, 32'h0);
    wb_wr(3'd0, 32'h9);
    check("down_m1", count, 32'hFFFF_FFFF);
    step();
    check("down_m2", count, 32'hFFFF_FFFE);
    check("down_nomatch", 32'(match), 32'h0);
    wb_wr(3'd0, 32'h0);

    // One-shot with auto-reload
    wb_wr(3'd3, 32'h0); wb_wr(3'd2, 32'd2);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE; wdat = 32'h13;
    step(); bus_idle();
    step(); check("os_cnt1", count, 32'd1);
    step(); check("os_reload", count, 32'd0);
    check("os_match", 32'(match), 32'h1);
    wb_cycle(1'b0, 3'd4, 32'h0, 4'hF, r, a);
    check("os_status", r, 32'h1);
    repeat (3) step();
    check("os_stays", count, 32'd0);

    // Priority: bus write beats LA load beats tick
    wb_wr(3'd2, 32'hFFFF_0000); wb_wr(3'd0, 32'h1);
    la_load = 1; la_data = 32'h55;
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE | 32'hC; wdat = 32'h100;
    step(); check("prio_wb", count, 32'h100);
    bus_idle();
    step(); check("prio_la", count, 32'h55);
    la_load = 0;
    wb_wr(3'd0, 32'h0);

    // Byte-lane write, then asynchronous reset during ack
    wb_wr(3'd3, 32'h1122_3344);
    wb_cycle(1'b1, 3'd3, 32'hAABB_CCDD, 4'b0010, r, a);
    check("sel_count", count, 32'h1122_CC44);
    wb_wr(3'd0, 32'h1);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE | 32'hC; wdat = 32'h777;
    step(); check("rst_pre_ack", 32'(ack), 32'h1);
    #2 rst = 1;
    #1;
    model_reset();
    check("rst_async_ack", 32'(ack), 32'h0);
    check("rst_async_count", count, 32'h0);
    bus_idle();
    @(posedge clk); #1;
    check("rst_hold_count", count, 32'h0);
    rst = 0;
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int o;
      if ($urandom_range(0, 2) == 0) begin
        o = $urandom_range(0, 7);
        cyc = 1; stb = ($urandom_range(0, 7) != 0);
        we = $urandom_range(0, 1);
        adr = ($urandom_range(0, 15) == 0) ? 32'h3000_0200 | (o << 2) : BASE | (o << 2);
        sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        case (o)
          0: wdat = $urandom_range(0, 31);
          1: wdat = $urandom_range(0, 3);
          2, 3: wdat = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                   : $urandom_range(0, 12);
          default: wdat = $urandom;
        endcase
      end else begin
        bus_idle();
      end
      la_load = ($urandom_range(0, 15) == 0);
      la_data = $urandom_range(0, 12);
      step();
    end
    bus_idle(); la_load = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
